// File: rtl/sd_frame_seq.sv
// SD command sequencer: one card init, then BLK_PER_FRAME read/stream block pairs per image, then hold.
// Define SD_SEQ_AUTO_ADVANCE_EN for the slideshow dwell timer that advances images on its own.
module sd_frame_seq #(
  parameter int unsigned BLK_PER_FRAME = 300,
  parameter int unsigned IMG_COUNT     = 16,
  parameter int unsigned ACK_TIMEOUT   = 4
`ifdef SD_SEQ_AUTO_ADVANCE_EN
  ,
  parameter logic [31:0] DWELL_CYCLES  = 32'd50_000_000
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       next_img,
  output logic       init,
  output logic       read_cmd,
  output logic       stream_512B,
  output logic       end_of_frame,
  output logic [3:0] img_id,
  output logic       if_begin,
  input  logic       if_busy,
  output logic       frame_done,
  output logic       loading,
  output logic       seq_err
);
  localparam int unsigned BLK_W = (BLK_PER_FRAME > 1) ? $clog2(BLK_PER_FRAME) : 1;
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLK_PER_FRAME - 1);
  localparam logic [3:0]       IMG_LAST = 4'(IMG_COUNT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_GO, S_ACK, S_DONE, S_HOLD} state_t;
  typedef enum logic [1:0] {OP_INIT, OP_RD, OP_ST} op_t;

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       img_q, img_d;
  logic             pend_q, pend_d;
  logic             frame_done_q, frame_done_d;
  logic             loading_q, loading_d;
  logic             seq_err_q, seq_err_d;
  logic             init_q, read_cmd_q, stream_q, eof_q, if_begin_q;
  logic             in_op_d;
  logic             advance;

`ifdef SD_SEQ_AUTO_ADVANCE_EN
  logic [31:0] dwell_q, dwell_d;

  // Zero outside HOLD, so the first HOLD cycle always sees a cleared counter.
  always_comb dwell_d = (state_q == S_HOLD) ? dwell_q + 32'd1 : 32'd0;
  assign advance = pend_q || (dwell_q == DWELL_CYCLES - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dwell_q <= 32'd0;
    else        dwell_q <= dwell_d;
  end
`else
  assign advance = pend_q;
`endif

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    blk_d        = blk_q;
    cnt_d        = cnt_q;
    img_d        = img_q;
    pend_d       = pend_q | next_img;
    frame_done_d = 1'b0;
    loading_d    = loading_q;
    seq_err_d    = seq_err_q;
    case (state_q)
      S_IDLE: if (start) begin
        seq_err_d = 1'b0;
        blk_d     = '0;
        op_d      = OP_INIT;
        cnt_d     = '0;
        loading_d = 1'b1;
        state_d   = S_SETUP;
      end
      S_SETUP: if (cnt_q == CNT_W'(1)) begin
        cnt_d   = '0;
        state_d = S_GO;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      // cnt enters ACK at 1 so it equals the number of cycles elapsed since GO.
      S_GO: begin
        cnt_d   = CNT_W'(1);
        state_d = S_ACK;
      end
      S_ACK: if (if_busy) begin
        state_d = S_DONE;
      end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
        seq_err_d = 1'b1;
        loading_d = 1'b0;
        state_d   = S_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      S_DONE: if (!if_busy) begin
        cnt_d   = '0;
        state_d = S_SETUP;
        case (op_q)
          OP_INIT: op_d = OP_RD;
          OP_RD:   op_d = OP_ST;
          default: if (blk_q == BLK_LAST) begin
            blk_d        = '0;
            frame_done_d = 1'b1;
            loading_d    = 1'b0;
            state_d      = S_HOLD;
          end else begin
            blk_d = blk_q + 1'b1;
            op_d  = OP_RD;
          end
        endcase
      end
      S_HOLD: if (advance) begin
        pend_d    = next_img;
        img_d     = (img_q == IMG_LAST) ? 4'd0 : img_q + 4'd1;
        op_d      = OP_RD;
        cnt_d     = '0;
        loading_d = 1'b1;
        state_d   = S_SETUP;
      end
      default: state_d = S_IDLE;
    endcase
    in_op_d = (state_d == S_SETUP) || (state_d == S_GO) ||
              (state_d == S_ACK)   || (state_d == S_DONE);
  end

  // Op outputs are registered copies of the next state, so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_INIT;
      blk_q        <= '0;
      cnt_q        <= '0;
      img_q        <= 4'd0;
      pend_q       <= 1'b0;
      frame_done_q <= 1'b0;
      loading_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      init_q       <= 1'b0;
      read_cmd_q   <= 1'b0;
      stream_q     <= 1'b0;
      eof_q        <= 1'b0;
      if_begin_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      blk_q        <= blk_d;
      cnt_q        <= cnt_d;
      img_q        <= img_d;
      pend_q       <= pend_d;
      frame_done_q <= frame_done_d;
      loading_q    <= loading_d;
      seq_err_q    <= seq_err_d;
      init_q       <= in_op_d && (op_d == OP_INIT);
      read_cmd_q   <= in_op_d && (op_d == OP_RD);
      stream_q     <= in_op_d && (op_d == OP_ST);
      eof_q        <= in_op_d && (op_d == OP_ST) && (blk_d == BLK_LAST);
      if_begin_q   <= (state_d == S_GO);
    end
  end

  assign init         = init_q;
  assign read_cmd     = read_cmd_q;
  assign stream_512B  = stream_q;
  assign end_of_frame = eof_q;
  assign img_id       = img_q;
  assign if_begin     = if_begin_q;
  assign frame_done   = frame_done_q;
  assign loading      = loading_q;
  assign seq_err      = seq_err_q;
endmodule

// File: tb/tb_sd_frame_seq.sv
// Bench for sd_frame_seq: random-latency SD interface responder plus an op-log reference model.
module tb_sd_frame_seq;
  localparam int N    = 3;
  localparam int ACKT = 4;

  logic clk = 0, rst_n = 0, start = 0, next_img = 0, if_busy = 0;
  logic init, read_cmd, stream_512B, end_of_frame, if_begin, frame_done, loading, seq_err;
  logic [3:0] img_id;

  int     n_cmp = 0, n_err = 0;
  longint cyc = 0;
  bit     resp_en = 1;
  int     ack_delay = 1;
  int     exp_img = 0;

  sd_frame_seq #(.BLK_PER_FRAME(N), .IMG_COUNT(16), .ACK_TIMEOUT(ACKT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .next_img(next_img),
    .init(init), .read_cmd(read_cmd), .stream_512B(stream_512B), .end_of_frame(end_of_frame),
    .img_id(img_id), .if_begin(if_begin), .if_busy(if_busy), .frame_done(frame_done),
    .loading(loading), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  // SD interface model: busy rises ack_delay cycles after the if_begin cycle, for 1..12 cycles.
  longint rise_c = 0, fall_c = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      rise_c = 0;
      fall_c = 0;
    end else if (if_begin) begin
      if (resp_en) begin
        rise_c = cyc + ack_delay;
        fall_c = rise_c + $urandom_range(12, 1);
      end else begin
        rise_c = 0;
        fall_c = 0;
      end
    end
    if_busy <= rst_n && (cyc + 1 >= rise_c) && (cyc + 1 < fall_c);
    cyc     <= cyc + 1;
  end

  typedef struct {
    logic [2:0] bits; logic eof; logic [3:0] img; logic [2:0] h1, h2; longint c;
  } op_rec_t;
  typedef struct { longint c; logic ld, ld_prev; longint fall; } fd_rec_t;
  op_rec_t ops[$];
  fd_rec_t fds[$];

  logic [2:0] h1 = 0, h2 = 0;
  logic       ifb_prev = 0, busy_prev = 0, ld_prev = 0, se_prev = 0;
  longint     last_fall = 0, err_rise = -1;
  int         onehot_bad = 0, ifb_bad = 0, eof_bad = 0;

  always @(negedge clk) begin
    logic [2:0] b;
    b = {stream_512B, read_cmd, init};
    if (!$onehot0(b)) onehot_bad++;
    if (end_of_frame && !stream_512B) eof_bad++;
    if (if_begin && ifb_prev) ifb_bad++;
    if (busy_prev && !if_busy) last_fall = cyc;
    if (if_begin) ops.push_back(op_rec_t'{b, end_of_frame, img_id, h1, h2, cyc});
    if (frame_done) fds.push_back(fd_rec_t'{cyc, loading, ld_prev, last_fall});
    if (seq_err && !se_prev) err_rise = cyc;
    h2 = h1; h1 = b;
    ifb_prev = if_begin; busy_prev = if_busy; ld_prev = loading; se_prev = seq_err;
  end

  // Reference: frame = [INIT] then N x (RD, ST); only the last ST carries end_of_frame.
  function automatic void exp_op(input int i, input bit with_init,
                                 output logic [2:0] bits, output logic eof);
    int j;
    j = with_init ? i - 1 : i;
    if (with_init && i == 0) begin
      bits = 3'b001; eof = 1'b0;
    end else begin
      bits = (j % 2 == 0) ? 3'b010 : 3'b100;
      eof  = (j == 2 * N - 1);
    end
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic pulse_next();
    @(negedge clk); #2 next_img = 1;
    @(negedge clk); #2 next_img = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); #2 start = 1;
    @(negedge clk); #2 start = 0;
  endtask

  task automatic wait_fd(input int n0, input int budget, output bit ok);
    int k = 0;
    while (fds.size() <= n0 && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    ok = (fds.size() > n0);
  endtask

  function automatic logic [11:0] outs();
    return {init, read_cmd, stream_512B, end_of_frame, img_id, if_begin, frame_done, loading, seq_err};
  endfunction

  task automatic test_reset();
    rst_n = 0;
    cycles(3);
    n_cmp++;
    if (outs() !== 12'h000) begin
      n_err++; $display("FAIL reset_outputs: got %h want 000", outs());
    end
    @(negedge clk); #2 rst_n = 1;
    cycles(8);
    n_cmp++;
    if (outs() !== 12'h000 || ops.size() != 0) begin
      n_err++; $display("FAIL idle_no_start: outs=%h ops=%0d want 000/0", outs(), ops.size());
    end
    $display("test_reset done");
  endtask

  task automatic test_first_frame();
    bit ok; logic [2:0] eb; logic ee;
    ops.delete(); fds.delete(); exp_img = 0;
    pulse_start();
    wait_fd(0, 3000, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL first_frame_timeout: frame_done not seen"); end
    n_cmp++;
    if (ops.size() != 2 * N + 1) begin
      n_err++; $display("FAIL first_frame_opcount: got %0d want %0d", ops.size(), 2 * N + 1);
    end
    for (int i = 0; i < ops.size() && i < 2 * N + 1; i++) begin
      exp_op(i, 1, eb, ee);
      n_cmp++;
      if (ops[i].bits !== eb || ops[i].eof !== ee || ops[i].img !== 4'(exp_img) ||
          ops[i].h1 !== eb || ops[i].h2 !== eb) begin
        n_err++;
        $display("FAIL first_frame_op%0d: bits=%b eof=%b img=%0d pre=%b/%b want bits=%b eof=%b img=%0d",
                 i, ops[i].bits, ops[i].eof, ops[i].img, ops[i].h2, ops[i].h1, eb, ee, exp_img);
      end
    end
    cycles(20);
    n_cmp++;
    if (fds.size() != 1) begin n_err++; $display("FAIL frame_done_count: got %0d want 1", fds.size()); end
    if (fds.size() > 0) begin
      n_cmp++;
      if (fds[0].c !== fds[0].fall + 1) begin
        n_err++; $display("FAIL frame_done_timing: at %0d want %0d", fds[0].c, fds[0].fall + 1);
      end
      n_cmp++;
      if (fds[0].ld !== 1'b0 || fds[0].ld_prev !== 1'b1) begin
        n_err++; $display("FAIL loading_fall: ld=%b prev=%b want 0/1", fds[0].ld, fds[0].ld_prev);
      end
    end
    n_cmp++;
    if (seq_err !== 1'b0 || img_id !== 4'd0 || ops.size() != 2 * N + 1) begin
      n_err++; $display("FAIL hold_state: seq_err=%b img=%0d ops=%0d want 0/0/%0d", seq_err, img_id, ops.size(), 2 * N + 1);
    end
    $display("test_first_frame done: ops=%0d", ops.size());
  endtask

  task automatic test_advance_wrap();
    bit ok; logic [2:0] eb; logic ee;
    for (int k = 1; k <= 16; k++) begin
      ops.delete(); fds.delete();
      ack_delay = $urandom_range(ACKT, 1);
      cycles($urandom_range(20, 0));
      pulse_next();
      exp_img = (exp_img + 1) % 16;
      wait_fd(0, 3000, ok);
      n_cmp++;
      if (!ok || ops.size() != 2 * N) begin
        n_err++; $display("FAIL advance%0d_ops: done=%b ops=%0d want 1/%0d", k, ok, ops.size(), 2 * N);
      end
      for (int i = 0; i < ops.size() && i < 2 * N; i++) begin
        exp_op(i, 0, eb, ee);
        n_cmp++;
        if (ops[i].bits !== eb || ops[i].eof !== ee || ops[i].img !== 4'(exp_img) ||
            ops[i].h1 !== eb || ops[i].h2 !== eb) begin
          n_err++;
          $display("FAIL advance%0d_op%0d: bits=%b eof=%b img=%0d pre=%b/%b want bits=%b eof=%b img=%0d",
                   k, i, ops[i].bits, ops[i].eof, ops[i].img, ops[i].h2, ops[i].h1, eb, ee, exp_img);
        end
      end
      $display("advance %0d: img_id=%0d expected=%0d ack_delay=%0d", k, img_id, exp_img, ack_delay);
    end
    ack_delay = 1;
  endtask

  task automatic test_start_ignored();
    ops.delete();
    pulse_start();
    cycles(40);
    n_cmp++;
    if (ops.size() != 0 || loading !== 1'b0) begin
      n_err++; $display("FAIL start_in_hold: ops=%0d loading=%b want 0/0", ops.size(), loading);
    end
    $display("test_start_ignored done");
  endtask

  task automatic test_pending_collapse();
    bit ok; int base;
    ops.delete(); fds.delete();
    pulse_next();
    exp_img = (exp_img + 1) % 16;
    base = exp_img;
    for (int p = 0; p < 2; p++) begin
      cycles($urandom_range(10, 3));
      n_cmp++;
      if (loading !== 1'b1) begin n_err++; $display("FAIL collapse_pulse%0d_loading: got %b want 1", p, loading); end
      pulse_next();
    end
    wait_fd(0, 3000, ok);
    n_cmp++;
    if (!ok || ops.size() != 2 * N) begin
      n_err++; $display("FAIL collapse_frame1: done=%b ops=%0d want 1/%0d", ok, ops.size(), 2 * N);
    end
    for (int i = 0; i < ops.size(); i++) begin
      n_cmp++;
      if (ops[i].img !== 4'(base)) begin
        n_err++; $display("FAIL collapse_img_stable%0d: got %0d want %0d", i, ops[i].img, base);
      end
    end
    ops.delete();
    exp_img = (exp_img + 1) % 16;
    wait_fd(1, 3000, ok);
    n_cmp++;
    if (!ok || ops.size() != 2 * N || img_id !== 4'(exp_img)) begin
      n_err++; $display("FAIL collapse_frame2: done=%b ops=%0d img=%0d want 1/%0d/%0d", ok, ops.size(), img_id, 2 * N, exp_img);
    end
    ops.delete();
    cycles(150);
    n_cmp++;
    if (ops.size() != 0 || img_id !== 4'(exp_img)) begin
      n_err++; $display("FAIL collapse_single_advance: ops=%0d img=%0d want 0/%0d", ops.size(), img_id, exp_img);
    end
    $display("test_pending_collapse done: img_id=%0d", img_id);
  endtask

  task automatic test_ack_timeout();
    bit ok; int k; logic [2:0] eb; logic ee;
    ops.delete(); fds.delete();
    resp_en = 0;
    pulse_next();
    exp_img = (exp_img + 1) % 16;
    k = 0;
    while (seq_err !== 1'b1 && k < 100) begin cycles(1); k++; end
    n_cmp++;
    if (seq_err !== 1'b1) begin n_err++; $display("FAIL timeout_seq_err: got %b want 1", seq_err); end
    n_cmp++;
    if (ops.size() != 1 || err_rise != ops[0].c + ACKT + 1) begin
      n_err++; $display("FAIL timeout_timing: ops=%0d err_at=%0d want 1/%0d", ops.size(), err_rise,
                        ops.size() > 0 ? ops[0].c + ACKT + 1 : -1);
    end
    cycles(30);
    n_cmp++;
    if ({init, read_cmd, stream_512B, end_of_frame, if_begin, loading} !== 6'b0 || ops.size() != 1) begin
      n_err++; $display("FAIL timeout_idle: opbits=%b loading=%b ops=%0d want 000/0/1",
                        {stream_512B, read_cmd, init}, loading, ops.size());
    end
    resp_en = 1;
    ops.delete();
    pulse_start();
    cycles(1);
    n_cmp++;
    if (seq_err !== 1'b0) begin n_err++; $display("FAIL restart_clears_err: got %b want 0", seq_err); end
    wait_fd(0, 3000, ok);
    n_cmp++;
    if (!ok || ops.size() != 2 * N + 1) begin
      n_err++; $display("FAIL restart_frame: done=%b ops=%0d want 1/%0d", ok, ops.size(), 2 * N + 1);
    end
    for (int i = 0; i < ops.size() && i < 2 * N + 1; i++) begin
      exp_op(i, 1, eb, ee);
      n_cmp++;
      if (ops[i].bits !== eb || ops[i].eof !== ee || ops[i].img !== 4'(exp_img)) begin
        n_err++; $display("FAIL restart_op%0d: bits=%b eof=%b img=%0d want bits=%b eof=%b img=%0d",
                          i, ops[i].bits, ops[i].eof, ops[i].img, eb, ee, exp_img);
      end
    end
    $display("test_ack_timeout done: img_id=%0d", img_id);
  endtask

  task automatic test_ack_boundary();
    bit ok;
    ops.delete(); fds.delete();
    ack_delay = ACKT;
    pulse_next();
    exp_img = (exp_img + 1) % 16;
    wait_fd(0, 3000, ok);
    n_cmp++;
    if (!ok || seq_err !== 1'b0 || ops.size() != 2 * N || img_id !== 4'(exp_img)) begin
      n_err++; $display("FAIL ack_on_last_cycle: done=%b seq_err=%b ops=%0d img=%0d want 1/0/%0d/%0d",
                        ok, seq_err, ops.size(), img_id, 2 * N, exp_img);
    end
    ack_delay = 1;
    $display("test_ack_boundary done");
  endtask

  task automatic test_reset_mid_st();
    bit ok; int k;
    ops.delete(); fds.delete();
    pulse_next();
    k = 0;
    while (!(stream_512B === 1'b1 && if_busy === 1'b1) && k < 500) begin cycles(1); k++; end
    n_cmp++;
    if (stream_512B !== 1'b1) begin n_err++; $display("FAIL reset_mid_st_reach: stream=%b want 1", stream_512B); end
    #2 rst_n = 0;
    #1;
    n_cmp++;
    if (outs() !== 12'h000) begin n_err++; $display("FAIL reset_mid_st_outputs: got %h want 000", outs()); end
    @(negedge clk); #2 rst_n = 1;
    exp_img = 0;
    cycles(3);
    n_cmp++;
    if (outs() !== 12'h000) begin n_err++; $display("FAIL reset_mid_st_after: got %h want 000", outs()); end
    ops.delete(); fds.delete();
    pulse_start();
    wait_fd(0, 3000, ok);
    n_cmp++;
    if (!ok || ops.size() != 2 * N + 1 || ops[0].bits !== 3'b001 || img_id !== 4'd0) begin
      n_err++; $display("FAIL reset_reload: done=%b ops=%0d img=%0d want 1/%0d/0", ok, ops.size(), img_id, 2 * N + 1);
    end
    $display("test_reset_mid_st done");
  endtask

  task automatic test_invariants();
    n_cmp++;
    if (onehot_bad != 0 || ifb_bad != 0 || eof_bad != 0) begin
      n_err++; $display("FAIL invariants: onehot=%0d if_begin_wide=%0d eof_outside_st=%0d want 0/0/0",
                        onehot_bad, ifb_bad, eof_bad);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_advance_wrap();
    test_start_ignored();
    test_pending_collapse();
    test_ack_timeout();
    test_ack_boundary();
    test_reset_mid_st();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
